// File: rtl/simd_add_arbiter.sv
// Two-requester round-robin front end sharing one registered packed-SIMD lane adder.
// Latency: 1 cycle from operand accept to out_valid. Backpressure: a full, stalled result register drops both readies.
// Optional SIMD_ADD_SAT_EN selects unsigned per-lane saturation instead of modulo wrap.
module simd_add_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8,
    localparam int DATA_W   = NUM_LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_x,
    input  logic [DATA_W-1:0] req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_x,
    input  logic [DATA_W-1:0] req1_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_src
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              src_q, src_d;
    logic              last_grant_q, last_grant_d;

    logic              slot_free;
    logic              grant_vld;
    logic              grant_id;
    logic              transfer;
    logic [DATA_W-1:0] sel_x;
    logic [DATA_W-1:0] sel_y;
    logic [DATA_W-1:0] lane_sum;

    // Arbitration; readies are masked during reset so nothing transfers then.
    always_comb begin
        slot_free = (state_q == ST_EMPTY) | out_ready;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        grant_vld  = ~rst & slot_free & (req0_valid | req1_valid);
        req0_ready = grant_vld & ~grant_id;
        req1_ready = grant_vld & grant_id;
        transfer   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        sel_x      = grant_id ? req1_x : req0_x;
        sel_y      = grant_id ? req1_y : req0_y;
    end

    genvar g;
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
`ifdef SIMD_ADD_SAT_EN
        logic [LANE_W:0] wide;
        assign wide = {1'b0, sel_x[g*LANE_W +: LANE_W]} + {1'b0, sel_y[g*LANE_W +: LANE_W]};
        assign lane_sum[g*LANE_W +: LANE_W] = wide[LANE_W] ? {LANE_W{1'b1}} : wide[LANE_W-1:0];
`else
        assign lane_sum[g*LANE_W +: LANE_W] = sel_x[g*LANE_W +: LANE_W] + sel_y[g*LANE_W +: LANE_W];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            sum_q        <= '0;
            src_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            src_q        <= src_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A transfer wins over a consume so simultaneous load/drain keeps the register full.
    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        src_d        = src_q;
        last_grant_d = last_grant_q;
        if (transfer) begin
            state_d      = ST_FULL;
            sum_d        = lane_sum;
            src_d        = grant_id;
            last_grant_d = grant_id;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
        out_sum   = sum_q;
        out_src   = src_q;
    end

endmodule

// File: tb/tb_simd_add_arbiter.sv
// Scoreboard bench for simd_add_arbiter: a transaction-level model predicts grants and sums.
module tb_simd_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        out_valid, out_ready;
    logic [31:0] out_sum;
    logic        out_src;

    simd_add_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_src    (out_src)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] sum;
        logic        src;
    } res_t;

    res_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_full;
    bit   m_last;
    bit   acc0, acc1;

`ifdef SIMD_ADD_SAT_EN
    localparam logic [31:0] VEC_EXP = 32'h02FFFFFF;
`else
    localparam logic [31:0] VEC_EXP = 32'h0200FF00;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        int          a;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a = int'((x >> (8 * i)) & 32'hFF) + int'((y >> (8 * i)) & 32'hFF);
`ifdef SIMD_ADD_SAT_EN
            if (a > 255) a = 255;
`else
            a = a % 256;
`endif
            r = r | (32'(a) << (8 * i));
        end
        return r;
    endfunction

    // Model: predicts who is accepted this cycle and what the register will hold next.
    always @(negedge clk) begin : model
        bit   sf, g_vld, g;
        res_t r;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            check("ready_in_reset", 64'({req0_ready, req1_ready}), 64'(0));
            sb_q.delete();
            m_full = 1'b0;
            m_last = 1'b1;
        end else begin
            check("out_valid", 64'(out_valid), 64'(m_full));
            sf    = !m_full || out_ready;
            g_vld = sf && (req0_valid || req1_valid);
            g     = (req0_valid && req1_valid) ? !m_last : req1_valid;
            check("req0_ready", 64'(req0_ready), 64'(g_vld && !g));
            check("req1_ready", 64'(req1_ready), 64'(g_vld && g));
            if (g_vld) begin
                r.sum = g ? ref_sum(req1_x, req1_y) : ref_sum(req0_x, req0_y);
                r.src = g;
                sb_q.push_back(r);
                m_last = g;
                m_full = 1'b1;
                acc0   = !g;
                acc1   = g;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: got out_sum %0h with no expected entry", out_sum);
            end else begin
                check("out_sum", 64'(out_sum), 64'(sb_q[0].sum));
                check("out_src", 64'(out_src), 64'(sb_q[0].src));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_rand();
        if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 9) < 7);
            req0_x     = $urandom;
            req0_y     = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        end
        if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 9) < 7);
            req1_x     = $urandom;
            req1_y     = ($urandom_range(0, 3) == 0) ? 32'h80808080 : $urandom;
        end
        out_ready = ($urandom_range(0, 9) < 7);
        rst       = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_x = '0; req0_y = '0; req1_x = '0; req1_y = '0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        check("rst_out_src", 64'(out_src), 64'(0));

        // Known-vector lane add
        tick();
        req0_valid = 1'b1; req0_x = 32'h01FF7F80; req0_y = 32'h01018080; out_ready = 1'b1;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("vec_valid", 64'(out_valid), 64'(1));
        check("vec_sum", 64'(out_sum), 64'(VEC_EXP));
        check("vec_src", 64'(out_src), 64'(0));

        // Round-robin after reset
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1; req0_x = $urandom; req0_y = $urandom;
        req1_valid = 1'b1; req1_x = $urandom; req1_y = $urandom;
        out_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_ready0", 64'(req0_ready), 64'(k % 2 == 0));
            check("rr_ready1", 64'(req1_ready), 64'(k % 2 == 1));
            if (k > 0) check("rr_src", 64'(out_src), 64'((k - 1) % 2));
            tick();
            if (acc0) begin req0_x = $urandom; req0_y = $urandom; end
            if (acc1) begin req1_x = $urandom; req1_y = $urandom; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) tick();

        // Backpressure with both requesters waiting
        req0_valid = 1'b1; req0_x = 32'h04030201; req0_y = 32'h0; out_ready = 1'b0;
        tick();
        req0_x = $urandom; req0_y = $urandom;
        req1_valid = 1'b1; req1_x = $urandom; req1_y = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", 64'({req0_ready, req1_ready}), 64'(0));
            check("bp_sum", 64'(out_sum), 64'(32'h04030201));
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_one_grant", 64'(req0_ready ^ req1_ready), 64'(1));
        tick();
        if (acc0) req0_valid = 1'b0;
        if (acc1) req1_valid = 1'b0;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) tick();

        // Lone requester
        req1_valid = 1'b1; req1_x = $urandom; req1_y = $urandom;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("lone_ready1", 64'(req1_ready), 64'(1));
            check("lone_ready0", 64'(req0_ready), 64'(0));
            if (k > 0) check("lone_src", 64'(out_src), 64'(1));
            tick();
            req1_x = $urandom; req1_y = $urandom;
        end
        req1_valid = 1'b0;
        @(negedge clk);
        check("lone_src_last", 64'(out_src), 64'(1));
        tick();

        // Reset while a result is pending
        req0_valid = 1'b1; req0_x = $urandom; req0_y = $urandom; out_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        req1_valid = 1'b1; req1_x = $urandom; req1_y = $urandom;
        @(negedge clk);
        check("mid_rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
        tick();
        rst = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_sum", 64'(out_sum), 64'(0));
        tick();

        // Randomized traffic
        repeat (600) begin
            step_rand();
            tick();
        end
        rst = 1'b0;
        step_rand();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("drain_queue", 64'(sb_q.size()), 64'(0));
        check("drain_valid", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
